// File: rtl/eprisc_iobus_pkg.sv
// Shared definitions for the epRISC I/O bus master: FSM states, frame
// geometry, select codes and the frame byte selector.
package eprisc_iobus_pkg;

    typedef enum logic [1:0] {
        sInit  = 2'd0,
        sIdle  = 2'd1,
        sFrame = 2'd2,
        sDone  = 2'd3
    } state_t;

    // A frame is 6 bus-clock beats; only the first 4 carry data.
    localparam int FRAME_BEATS = 6;
    localparam int HALF_PHASES = 2 * FRAME_BEATS;
    localparam int DATA_BEATS  = 4;

    // Select 0 holds the controller in reset; select 1 addresses it.
    localparam logic [1:0] SEL_RESET  = 2'h0;
    localparam logic [1:0] SEL_ACTIVE = 2'h1;

    // Board cycles the controller is held in reset after our own reset.
    localparam int INIT_HOLD = 2;

    // Byte driven on MOSI for the rising edge that opens half-phase 'phase'.
    // Beats 1..4 carry the word LSB first, beats 5 and 6 carry zero.
    function automatic logic [7:0] frame_byte(input logic [31:0] word,
                                              input logic [3:0]  phase);
        logic [7:0] b;
        case (phase[3:1])
            3'd0:    b = word[7:0];
            3'd1:    b = word[15:8];
            3'd2:    b = word[23:16];
            3'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eprisc_sync2.sv
// Multi-flop synchroniser for a single asynchronous level input.
module eprisc_sync2 #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/eprisc_iobus_master.sv
// Host-side epRISC I/O bus master: turns one CPU request into one (write)
// or two (read) 6-beat byte-serial frames and returns the read word.
module eprisc_iobus_master
    import eprisc_iobus_pkg::*;
#(
    parameter int pClockDiv = 1
) (
    input  logic        iBoardClock,
    input  logic        iBoardReset,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWrite,
    input  logic [14:0] iReqAddr,
    input  logic [15:0] iReqData,
    output logic        oRspValid,
    output logic [31:0] oRspData,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO,
    input  logic        iBusInterrupt,
    output logic        oIrq
);

    localparam int DIV_W = (pClockDiv > 1) ? $clog2(pClockDiv) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(pClockDiv - 1);

    state_t            state_reg, state_next;
    logic [1:0]        init_cnt_reg, init_cnt_next;
    logic [31:0]       word_reg, word_next;
    logic [1:0]        frames_left_reg, frames_left_next;
    logic [3:0]        phase_reg, phase_next;
    logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
    logic              bus_clk_reg, bus_clk_next;
    logic [1:0]        bus_sel_reg, bus_sel_next;
    logic [7:0]        mosi_reg, mosi_next;
    logic [31:0]       shadow_reg, shadow_next;
    logic [31:0]       rsp_data_reg, rsp_data_next;

    logic [3:0]        phase_inc;
    logic [31:0]       word_rb;

    // Next-state logic: init hold, request acceptance, half-phase sequencing.
    always_comb begin
        state_next       = state_reg;
        init_cnt_next    = init_cnt_reg;
        word_next        = word_reg;
        frames_left_next = frames_left_reg;
        phase_next       = phase_reg;
        div_cnt_next     = div_cnt_reg;
        bus_clk_next     = bus_clk_reg;
        bus_sel_next     = bus_sel_reg;
        mosi_next        = mosi_reg;
        shadow_next      = shadow_reg;
        rsp_data_next    = rsp_data_reg;
        phase_inc        = phase_reg + 4'd1;
        // Read-back frame: same address and data, write flag cleared.
        word_rb          = {1'b0, word_reg[30:0]};

        case (state_reg)
            sInit: begin
                bus_sel_next = SEL_RESET;
                if (init_cnt_reg == 2'(INIT_HOLD - 1)) begin
                    state_next   = sIdle;
                    bus_sel_next = SEL_ACTIVE;
                end else begin
                    init_cnt_next = init_cnt_reg + 2'd1;
                end
            end

            sIdle: begin
                if (iReqValid) begin
                    word_next        = {iReqWrite, iReqAddr, iReqData};
                    frames_left_next = iReqWrite ? 2'd1 : 2'd2;
                    phase_next       = 4'd0;
                    div_cnt_next     = '0;
                    bus_clk_next     = 1'b1;
                    mosi_next        = frame_byte({iReqWrite, iReqAddr, iReqData}, 4'd0);
                    state_next       = sFrame;
                end
            end

            sFrame: begin
                if (div_cnt_reg != DIV_LAST) begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end else begin
                    div_cnt_next = '0;
                    if (phase_reg == 4'(HALF_PHASES - 1)) begin
                        if (frames_left_reg > 2'd1) begin
                            frames_left_next = frames_left_reg - 2'd1;
                            word_next        = word_rb;
                            phase_next       = 4'd0;
                            bus_clk_next     = 1'b1;
                            mosi_next        = frame_byte(word_rb, 4'd0);
                        end else begin
                            state_next = sDone;
                            // Bit 31 still set means this was a write.
                            if (!word_reg[31]) begin
                                rsp_data_next = shadow_reg;
                            end
                        end
                    end else begin
                        phase_next = phase_inc;
                        if (!phase_inc[0]) begin
                            bus_clk_next = 1'b1;
                            mosi_next    = frame_byte(word_reg, phase_inc);
                        end else begin
                            bus_clk_next = 1'b0;
                            // Controller's response byte is valid across the high phase.
                            if (phase_inc < 4'(2 * DATA_BEATS)) begin
                                shadow_next[{phase_inc[2:1], 3'b000} +: 8] = iBusMISO;
                            end
                        end
                    end
                end
            end

            sDone: begin
                state_next = sIdle;
            end

            default: begin
                state_next = sInit;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge iBoardClock or negedge iBoardReset) begin
        if (!iBoardReset) begin
            state_reg       <= sInit;
            init_cnt_reg    <= 2'd0;
            word_reg        <= '0;
            frames_left_reg <= 2'd0;
            phase_reg       <= 4'd0;
            div_cnt_reg     <= '0;
            bus_clk_reg     <= 1'b0;
            bus_sel_reg     <= SEL_RESET;
            mosi_reg        <= 8'h00;
            shadow_reg      <= '0;
            rsp_data_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            init_cnt_reg    <= init_cnt_next;
            word_reg        <= word_next;
            frames_left_reg <= frames_left_next;
            phase_reg       <= phase_next;
            div_cnt_reg     <= div_cnt_next;
            bus_clk_reg     <= bus_clk_next;
            bus_sel_reg     <= bus_sel_next;
            mosi_reg        <= mosi_next;
            shadow_reg      <= shadow_next;
            rsp_data_reg    <= rsp_data_next;
        end
    end

    assign oReqReady  = (state_reg == sIdle);
    assign oRspValid  = (state_reg == sDone);
    assign oRspData   = rsp_data_reg;
    assign oBusClock  = bus_clk_reg;
    assign oBusSelect = bus_sel_reg;
    assign oBusMOSI   = mosi_reg;

    eprisc_sync2 #(
        .STAGES (2)
    ) u_irq_sync (
        .clk   (iBoardClock),
        .rst_n (iBoardReset),
        .d     (iBusInterrupt),
        .q     (oIrq)
    );

endmodule

// File: tb/tb_eprisc_iobus_master.sv
// Self-checking bench for eprisc_iobus_master with a behavioural controller.
module tb_eprisc_iobus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [14:0] req_addr  = '0;
    logic [15:0] req_data  = '0;
    logic        req_ready, rsp_valid, bus_clk, irq;
    logic [31:0] rsp_data;
    logic [1:0]  bus_sel;
    logic [7:0]  mosi;
    logic [7:0]  miso      = 8'h00;
    logic        bus_int   = 1'b0;

    logic        req_valid3 = 1'b0;
    logic        req_ready3, rsp_valid3, bus_clk3, irq3;
    logic [31:0] rsp_data3;
    logic [1:0]  bus_sel3;
    logic [7:0]  mosi3;
    logic [7:0]  miso3 = 8'h00;

    eprisc_iobus_master #(.pClockDiv(1)) dut (
        .iBoardClock(clk), .iBoardReset(rst_n),
        .iReqValid(req_valid), .oReqReady(req_ready), .iReqWrite(req_write),
        .iReqAddr(req_addr), .iReqData(req_data),
        .oRspValid(rsp_valid), .oRspData(rsp_data),
        .oBusClock(bus_clk), .oBusSelect(bus_sel), .oBusMOSI(mosi),
        .iBusMISO(miso), .iBusInterrupt(bus_int), .oIrq(irq)
    );

    eprisc_iobus_master #(.pClockDiv(3)) dut3 (
        .iBoardClock(clk), .iBoardReset(rst_n),
        .iReqValid(req_valid3), .oReqReady(req_ready3), .iReqWrite(req_write),
        .iReqAddr(req_addr), .iReqData(req_data),
        .oRspValid(rsp_valid3), .oRspData(rsp_data3),
        .oBusClock(bus_clk3), .oBusSelect(bus_sel3), .oBusMOSI(mosi3),
        .iBusMISO(miso3), .iBusInterrupt(bus_int), .oIrq(irq3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Controller register file as seen by the host: a fixed word per address.
    function automatic logic [31:0] ctrl_resp(input logic [14:0] a);
        if (a == 15'h0300) return 32'h1234ABCD;
        return {a, 1'b1, ~a, 1'b0} ^ 32'hA5C3_0F96;
    endfunction

    // Behavioural controller: beat counter on the bus clock, MOSI collected
    // on falling edges, the answer for the previous frame's address on MISO.
    int          rise_cnt   = 0;
    int          total_rise = 0;
    int          got_cnt    = 0;
    int          pad_bad    = 0;
    logic [31:0] rx_word    = '0;
    logic [31:0] resp_word  = '0;
    logic [31:0] got_frames [0:511];

    always @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt <= 0;
            miso     <= 8'h00;
        end else begin
            total_rise <= total_rise + 1;
            if (bus_sel == 2'h1) begin
                miso     <= ((rise_cnt % 6) < 4) ? resp_word[8*(rise_cnt % 6) +: 8] : 8'h00;
                rise_cnt <= rise_cnt + 1;
            end
        end
    end

    always @(negedge bus_clk) begin
        if (rst_n && bus_sel == 2'h1 && rise_cnt > 0) begin
            if (((rise_cnt - 1) % 6) < 4) rx_word[8*((rise_cnt - 1) % 6) +: 8] <= mosi;
            else if (mosi != 8'h00) pad_bad <= pad_bad + 1;
            if (((rise_cnt - 1) % 6) == 5 && got_cnt < 512) begin
                got_frames[got_cnt] <= rx_word;
                got_cnt   <= got_cnt + 1;
                resp_word <= ctrl_resp(rx_word[30:16]);
            end
        end
    end

    int          rd_idx    = 0;
    logic [31:0] last_read = '0;

    task automatic check_frames(input logic w, input logic [14:0] a, input logic [15:0] d);
        int nf;
        nf = w ? 1 : 2;
        for (int n = 0; n < nf; n++) begin
            if (rd_idx < got_cnt) begin
                check($sformatf("frame%0d_word", rd_idx), got_frames[rd_idx], {w, a, d});
                rd_idx++;
            end else begin
                n_checks++;
                $display("FAIL frame_missing: got %0d frames required %0d", got_cnt, rd_idx + 1);
            end
        end
        check("mosi_pad_errors", pad_bad, 0);
    endtask

    task automatic check_init_seq(input string tag);
        @(negedge clk);
        check({tag, "_sel_hold"}, 32'(bus_sel), 32'h0);
        check({tag, "_ready_hold"}, 32'(req_ready), 32'h0);
        @(negedge clk);
        check({tag, "_sel_active"}, 32'(bus_sel), 32'h1);
        check({tag, "_ready_idle"}, 32'(req_ready), 32'h1);
    endtask

    task automatic run_req(input logic w, input logic [14:0] a, input logic [15:0] d,
                           output int lat, output int rises, output logic [31:0] rdata);
        int r0, budget, busy_ready;
        budget = 0;
        req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
        while (!req_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        r0 = total_rise;
        @(negedge clk);
        lat = 1;
        busy_ready = 0;
        while (!rsp_valid && lat < 100) begin
            if (req_ready) busy_ready++;
            // Junk on the request lines while busy must be ignored.
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 15'($urandom);
            req_data  = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        rises = total_rise - r0;
        rdata = rsp_data;
        check("ready_low_busy", busy_ready, 0);
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'h0);
        check("ready_return", 32'(req_ready), 32'h1);
        check_frames(w, a, d);
    endtask

    typedef struct {
        logic        w;
        logic [14:0] a;
        logic [15:0] d;
        int          lat;
        int          rises;
        logic [31:0] rsp;
    } vec_t;

    vec_t        vecs [6];
    int          lat, rises;
    logic [31:0] rd;

    int   cyc, acc0, acc1, rsp0, rsp1, nacc, nrsp, ready_hi, gap_bad, r0, accepted_now;
    logic [31:0] rd1;
    int   rsp_seen, budget;
    int   cyc3, last_t, nint, bad_int, first_edge, beat3, pad3;
    logic prev3;
    logic [31:0] w3;
    logic old_irq;
    logic rw;
    logic [14:0] ra;
    logic [15:0] rdd;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 15'h0300, 16'hBEEF, 13, 6,  32'h0000_0000};
        vecs[1] = '{1'b0, 15'h0300, 16'hDEAD, 25, 12, 32'h1234_ABCD};
        vecs[2] = '{1'b1, 15'h7FFF, 16'h0001, 13, 6,  32'h1234_ABCD};
        vecs[3] = '{1'b0, 15'h0000, 16'h0000, 25, 12, ctrl_resp(15'h0000)};
        vecs[4] = '{1'b0, 15'h7FFF, 16'hFFFF, 25, 12, ctrl_resp(15'h7FFF)};
        vecs[5] = '{1'b1, 15'h0000, 16'hFFFF, 13, 6,  ctrl_resp(15'h7FFF)};

        // Reset values.
        #12;
        check("rst_bus_clk", 32'(bus_clk), 32'h0);
        check("rst_sel", 32'(bus_sel), 32'h0);
        check("rst_mosi", 32'(mosi), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check_init_seq("init");

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].w, vecs[i].a, vecs[i].d, lat, rises, rd);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_rises", i), rises, vecs[i].rises);
            check($sformatf("vec%0d_rsp_data", i), rd, vecs[i].rsp);
        end
        last_read = vecs[5].rsp;

        // Back-to-back write then read with valid held high.
        r0 = total_rise; nacc = 0; nrsp = 0; cyc = 0; ready_hi = 0; gap_bad = 0;
        acc0 = -100; acc1 = -100; rsp0 = -100; rsp1 = -100; rd1 = '0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0155; req_data = 16'h1357;
        while (nrsp < 2 && cyc < 200) begin
            if (rsp_valid) begin
                if (nrsp == 0) rsp0 = cyc;
                else begin rsp1 = cyc; rd1 = rsp_data; end
                nrsp++;
            end
            if (req_ready) ready_hi++;
            if (nrsp == 1 && cyc <= rsp0 + 1 && bus_clk) gap_bad++;
            accepted_now = 0;
            if (req_ready && req_valid) begin
                if (nacc == 0) acc0 = cyc; else acc1 = cyc;
                nacc++;
                accepted_now = 1;
            end
            @(negedge clk);
            cyc++;
            if (accepted_now == 1) begin
                if (nacc == 1) begin req_write = 1'b0; req_data = 16'h2468; end
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts", nacc, 2);
        check("b2b_responses", nrsp, 2);
        check("b2b_ready_cycles", ready_hi, 2);
        check("b2b_write_latency", rsp0 - acc0, 13);
        check("b2b_second_accept", acc1, rsp0 + 1);
        check("b2b_read_latency", rsp1 - acc1, 25);
        check("b2b_gap_clock_low", gap_bad, 0);
        check("b2b_rises", total_rise - r0, 18);
        check("b2b_read_data", rd1, ctrl_resp(15'h0155));
        check_frames(1'b1, 15'h0155, 16'h1357);
        check_frames(1'b0, 15'h0155, 16'h2468);
        @(negedge clk);

        // Reset in the middle of a read, at half-phase 5.
        req_write = 1'b0; req_addr = 15'h0355; req_data = 16'h5A5A; req_valid = 1'b1;
        budget = 0;
        while (!req_ready && budget < 50) begin @(negedge clk); budget++; end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("midrst_mosi_before", 32'(mosi), 32'h55);
        rst_n = 1'b0;
        #1;
        check("midrst_bus_clk", 32'(bus_clk), 32'h0);
        check("midrst_sel", 32'(bus_sel), 32'h0);
        check("midrst_mosi", 32'(mosi), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_rsp_data", rsp_data, 32'h0);
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        rst_n = 1'b1;
        check_init_seq("midrst");
        check("midrst_no_rsp", rsp_seen, 0);
        check("midrst_no_frame", got_cnt, rd_idx);
        last_read = '0;

        // Randomised requests against the reference model.
        for (int i = 0; i < 30; i++) begin
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       ra = 15'h0300;
                1:       ra = 15'h0000;
                2:       ra = 15'h7FFF;
                default: ra = 15'($urandom);
            endcase
            rdd = 16'($urandom);
            run_req(rw, ra, rdd, lat, rises, rd);
            if (!rw) last_read = ctrl_resp(ra);
            check($sformatf("rnd%0d_latency", i), lat, rw ? 13 : 25);
            check($sformatf("rnd%0d_rises", i), rises, rw ? 6 : 12);
            check($sformatf("rnd%0d_rsp_data", i), rd, last_read);
        end

        // Divided bus clock: pClockDiv = 3 write.
        req_write = 1'b1; req_addr = 15'h2A5C; req_data = 16'hC0DE; req_valid3 = 1'b1;
        budget = 0;
        while (!req_ready3 && budget < 50) begin @(negedge clk); budget++; end
        @(negedge clk);
        req_valid3 = 1'b0;
        cyc3 = 1; prev3 = 1'b0; last_t = -1; nint = 0; bad_int = 0; first_edge = -1;
        beat3 = 0; pad3 = 0; w3 = '0;
        while (!rsp_valid3 && cyc3 < 200) begin
            if (bus_clk3 != prev3) begin
                if (last_t >= 0) begin
                    if (cyc3 - last_t != 3) bad_int++;
                    nint++;
                end else begin
                    first_edge = cyc3;
                end
                last_t = cyc3;
                if (bus_clk3) begin
                    if (beat3 < 4) w3[8*beat3 +: 8] = mosi3;
                    else if (mosi3 != 8'h00) pad3++;
                    beat3++;
                end
            end
            prev3 = bus_clk3;
            @(negedge clk);
            cyc3++;
        end
        check("div3_latency", cyc3, 37);
        check("div3_first_edge", first_edge, 1);
        check("div3_rises", beat3, 6);
        check("div3_intervals", nint, 11);
        check("div3_bad_intervals", bad_int, 0);
        check("div3_word", w3, {1'b1, 15'h2A5C, 16'hC0DE});
        check("div3_pad", pad3, 0);
        check("div3_rsp_data", rsp_data3, 32'h0);

        // Asynchronous interrupt through the synchroniser.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #($urandom_range(1, 4));
            old_irq = bus_int;
            bus_int = ~bus_int;
            @(posedge clk);
            #1;
            check($sformatf("irq%0d_stage1", i), 32'(irq), 32'(old_irq));
            @(posedge clk);
            #1;
            check($sformatf("irq%0d_stage2", i), 32'(irq), 32'(bus_int));
            check($sformatf("irq%0d_div3", i), 32'(irq3), 32'(bus_int));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
